// File: rtl/dcache_port_responder.sv
// Data-cache port responder: answers index/tag-phase requests from a backing
// memory with fixed read latency, kill handling and saturating statistics.
package dcache_port_pkg;
  typedef struct packed {
    logic [11:0] address_index;
    logic [43:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_port_responder
  import dcache_port_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  dcache_req_i_t req_i,
  output dcache_req_o_t req_o,
  input  logic          stall_i,
  output logic          busy_o,
  output logic [15:0]   num_reads_o,
  output logic [15:0]   num_kills_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, TAG, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [11:0]   index_q;
  logic          we_q;
  logic [7:0]    be_q;
  logic [63:0]   wdata_q;
  logic [AW-1:0] raddr_q;
  logic [63:0]   mem_q [MEM_WORDS];
  logic [15:0]   num_reads_q, num_kills_q;

  logic          gnt;
  logic          do_write;
  logic          do_kill;
  logic          latch_addr;
  logic [55:0]   full_addr;
  logic [AW-1:0] tag_addr;
  logic          unused_bits;

  // Tag arrives one cycle after the index, so the address is formed from the live tag and captured index.
  assign full_addr   = {req_i.address_tag, index_q};
  assign tag_addr    = full_addr[3 +: AW];
  assign unused_bits = ^{req_i.data_size, full_addr};

  // Grant is gated by reset so it is low immediately while rst_ni is asserted.
  assign gnt = rst_ni && req_i.data_req && !stall_i && (state_q == IDLE || state_q == RESP);

  assign req_o.data_gnt    = gnt;
  assign req_o.data_rvalid = (state_q == RESP);
  assign req_o.data_rdata  = (state_q == RESP) ? mem_q[raddr_q] : 64'h0;
  assign busy_o            = (state_q != IDLE);
  assign num_reads_o       = num_reads_q;
  assign num_kills_o       = num_kills_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    do_write   = 1'b0;
    do_kill    = 1'b0;
    latch_addr = 1'b0;
    case (state_q)
      IDLE: if (gnt) state_d = TAG;
      TAG: begin
        if (req_i.kill_req || !req_i.tag_valid) begin
          do_kill = 1'b1;
          state_d = IDLE;
        end else if (we_q) begin
          do_write = 1'b1;
          state_d  = IDLE;
        end else begin
          latch_addr = 1'b1;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (req_i.kill_req) begin
          do_kill = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = RESP;
        end
      end
      RESP: state_d = gnt ? TAG : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      if (gnt) begin
        index_q <= req_i.address_index;
        we_q    <= req_i.data_we;
        be_q    <= req_i.data_be;
        wdata_q <= req_i.data_wdata;
      end
      if (latch_addr) raddr_q <= tag_addr;
    end
  end

  // Backing store reloads its identity pattern on every reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= {32'(i), ~32'(i)};
    end else if (do_write) begin
      for (int b = 0; b < 8; b++)
        if (be_q[b]) mem_q[tag_addr][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      num_reads_q <= '0;
      num_kills_q <= '0;
    end else begin
      if (req_o.data_rvalid && num_reads_q != 16'hFFFF) num_reads_q <= num_reads_q + 16'd1;
      if (do_kill && num_kills_q != 16'hFFFF) num_kills_q <= num_kills_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_dcache_port_responder.sv
// Randomized self-checking bench for dcache_port_responder against a
// transaction-level memory/counter model.
module tb_dcache_port_responder;
  import dcache_port_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int LAT       = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          stall = 1'b0;
  dcache_req_i_t req = '0;
  dcache_req_o_t rsp;
  logic          busy;
  logic [15:0]   num_reads, num_kills;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_reads = 0;
  int exp_kills = 0;
  logic [63:0] model [MEM_WORDS];

  dcache_port_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
    .clk(clk), .rst_ni(rst_ni), .req_i(req), .req_o(rsp), .stall_i(stall),
    .busy_o(busy), .num_reads_o(num_reads), .num_kills_o(num_kills)
  );

  always #5 clk = ~clk;

  task automatic init_model();
    for (int i = 0; i < MEM_WORDS; i++) model[i] = {32'(i), ~32'(i)};
    exp_reads = 0;
    exp_kills = 0;
  endtask

  function automatic int word_of(logic [11:0] idx, logic [43:0] tag);
    logic [55:0] full;
    full = {tag, idx};
    return int'((full / 8) % MEM_WORDS);
  endfunction

  // One complete transaction; returns grant wait, first rvalid latency after grant, rvalid count, data.
  task automatic issue(input logic [11:0] idx, input logic [43:0] tag, input logic we,
                       input logic [7:0] be, input logic [63:0] wd, input bit kill_tag,
                       input bit tvalid, input bit kill_wait, output int wait_cyc,
                       output int lat, output int n_rv, output int n_dirty, output logic [63:0] data);
    wait_cyc = 0; lat = -1; n_rv = 0; n_dirty = 0; data = '0;
    req.data_req = 1'b1; req.address_index = idx; req.data_we = we; req.data_be = be;
    req.data_wdata = wd; req.data_size = 2'($urandom); req.kill_req = 1'b0; req.tag_valid = 1'b0;
    @(negedge clk);
    while (!rsp.data_gnt && wait_cyc < 20) begin
      @(posedge clk); #1; @(negedge clk); wait_cyc++;
    end
    if (!rsp.data_gnt) begin
      wait_cyc = -1; req.data_req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req.data_req = 1'b0; req.address_index = 12'($urandom); req.data_we = 1'($urandom);
    req.data_be = 8'($urandom); req.data_wdata = {$urandom, $urandom};
    req.address_tag = tag; req.tag_valid = tvalid; req.kill_req = kill_tag;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp.data_rvalid) begin
        n_rv++;
        if (lat < 0) begin lat = k; data = rsp.data_rdata; end
      end else if (rsp.data_rdata !== 64'h0) n_dirty++;
      @(posedge clk); #1;
      req.tag_valid = 1'b0; req.address_tag = {12'($urandom), $urandom};
      req.kill_req = (kill_wait && k == 1) || (!kill_wait && k == LAT && 1'($urandom));
    end
    req.kill_req = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; req.data_req = 1'b1; stall = 1'b0; rst_ni = 1'b0;
    #3;
    n_checks++;
    if (rsp.data_gnt !== 1'b0 || rsp.data_rvalid !== 1'b0 || rsp.data_rdata !== 64'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h busy=%b expected all zero",
               rsp.data_gnt, rsp.data_rvalid, rsp.data_rdata, busy);
    end
    n_checks++;
    if (num_reads !== 16'h0 || num_kills !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_counters: got reads=%h kills=%h expected 0", num_reads, num_kills);
    end
    req.data_req = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    init_model();
  endtask

  task automatic test_basic_read();
    int w, l, n, d; logic [63:0] data;
    issue(12'h010, 44'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
    exp_reads++;
    n_checks++;
    if (w !== 0 || l !== LAT + 1 || n !== 1) begin
      n_fail++;
      $display("[TB] FAIL basic_read_timing: got wait=%0d lat=%0d rvalids=%0d expected 0/%0d/1", w, l, n, LAT + 1);
    end
    n_checks++;
    if (data !== 64'h00000002_FFFFFFFD || num_reads !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL basic_read_data: got %h reads=%0d expected 00000002fffffffd reads=1", data, num_reads);
    end
  endtask

  task automatic test_write_read();
    int w, l, n, d; logic [63:0] data;
    issue(12'h028, 44'h0, 1'b1, 8'h0F, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
    model[5][31:0] = 32'h3333_4444;
    n_checks++;
    if (n !== 0) begin
      n_fail++;
      $display("[TB] FAIL write_no_rvalid: got %0d rvalids expected 0", n);
    end
    issue(12'h028, 44'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
    exp_reads++;
    n_checks++;
    if (data !== 64'h00000005_33334444 || l !== LAT + 1) begin
      n_fail++;
      $display("[TB] FAIL write_read_data: got %h lat=%0d expected 0000000533334444 lat=%0d", data, l, LAT + 1);
    end
  endtask

  task automatic test_kill();
    req = '0; req.data_req = 1'b1; req.address_index = 12'h040;
    @(negedge clk);
    n_checks++;
    if (rsp.data_gnt !== 1'b1) begin
      n_fail++; $display("[TB] FAIL kill_tag_gnt: got %b expected 1", rsp.data_gnt);
    end
    @(posedge clk); #1;
    req.data_req = 1'b0; req.tag_valid = 1'b1; req.kill_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL kill_tag_busy: got %b expected 1", busy);
    end
    @(posedge clk); #1;
    req.tag_valid = 1'b0; req.kill_req = 1'b0;
    exp_kills++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rsp.data_rvalid !== 1'b0 || num_kills !== 16'(exp_kills)) begin
      n_fail++;
      $display("[TB] FAIL kill_tag_after: got busy=%b rvalid=%b kills=%0d expected 0/0/%0d",
               busy, rsp.data_rvalid, num_kills, exp_kills);
    end
    @(posedge clk); #1;
    // Kill in the WAIT phase of a read.
    req.data_req = 1'b1; req.address_index = 12'h040;
    @(posedge clk); #1;
    req.data_req = 1'b0; req.tag_valid = 1'b1;
    @(posedge clk); #1;
    req.tag_valid = 1'b0; req.kill_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL kill_wait_busy: got %b expected 1", busy);
    end
    @(posedge clk); #1;
    req.kill_req = 1'b0;
    exp_kills++;
    begin
      int rv = 0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || num_kills !== 16'(exp_kills)) begin
        n_fail++;
        $display("[TB] FAIL kill_wait_after: got busy=%b kills=%0d expected 0/%0d", busy, num_kills, exp_kills);
      end
      for (int k = 0; k < 4; k++) begin
        if (rsp.data_rvalid) rv++;
        @(posedge clk); #1; @(negedge clk);
      end
      n_checks++;
      if (rv !== 0 || num_reads !== 16'(exp_reads)) begin
        n_fail++;
        $display("[TB] FAIL kill_wait_rvalid: got rvalids=%0d reads=%0d expected 0/%0d", rv, num_reads, exp_reads);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int w, l, n, d, op, word, bad;
    logic [11:0] idx; logic [43:0] tag; logic [7:0] be; logic [63:0] wd, data;
    bit kt, tv, kw, we;
    bad = 0;
    for (int it = 0; it < 40; it++) begin
      op  = int'($urandom_range(0, 4));
      idx = 12'($urandom);
      tag = ($urandom_range(0, 3) == 0) ? {12'($urandom), $urandom} : 44'($urandom_range(0, 1));
      be  = 8'($urandom); wd = {$urandom, $urandom};
      we = (op == 2); kt = 1'b0; tv = 1'b1; kw = (op == 4);
      if (op == 3) begin
        we = 1'($urandom);
        if ($urandom_range(0, 1) == 1) kt = 1'b1; else tv = 1'b0;
        tv = kt ? 1'($urandom) : 1'b0;
      end
      word = word_of(idx, tag);
      issue(idx, tag, we, be, wd, kt, tv, kw, w, l, n, d, data);
      n_checks++;
      if (op <= 1) begin
        exp_reads++;
        if (w !== 0 || n !== 1 || l !== LAT + 1 || data !== model[word] || d !== 0) begin
          n_fail++; bad++;
          $display("[TB] FAIL random_read[%0d]: got lat=%0d n=%0d data=%h dirty=%0d expected lat=%0d n=1 data=%h",
                   it, l, n, data, d, LAT + 1, model[word]);
        end
      end else begin
        if (op == 2) begin
          for (int b = 0; b < 8; b++) if (be[b]) model[word][8*b +: 8] = wd[8*b +: 8];
        end else exp_kills++;
        if (w !== 0 || n !== 0 || d !== 0) begin
          n_fail++; bad++;
          $display("[TB] FAIL random_op%0d[%0d]: got wait=%0d rvalids=%0d dirty=%0d expected 0/0/0", op, it, w, n, d);
        end
      end
    end
    n_checks++;
    if (num_reads !== 16'(exp_reads) || num_kills !== 16'(exp_kills)) begin
      n_fail++;
      $display("[TB] FAIL random_counters: got reads=%0d kills=%0d expected %0d/%0d",
               num_reads, num_kills, exp_reads, exp_kills);
    end
  endtask

  task automatic test_back_to_back();
    int rv_cycle = -1; logic [63:0] data = '0;
    int bad_gnt = 0;
    req = '0; req.data_req = 1'b1; req.address_index = 12'h018; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (rsp.data_gnt !== 1'b0) bad_gnt++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad_gnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_gnt: got %0d grants busy=%b expected 0/0", bad_gnt, busy);
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp.data_gnt !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_release_gnt: got %b expected 1", rsp.data_gnt);
    end
    @(posedge clk); #1;
    req.tag_valid = 1'b1; req.address_tag = '0; req.address_index = 12'h020;
    bad_gnt = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk); if (rsp.data_gnt !== 1'b0 || rsp.data_rvalid !== 1'b0) bad_gnt++;
      @(posedge clk); #1; req.tag_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bad_gnt !== 0 || rsp.data_rvalid !== 1'b1 || rsp.data_gnt !== 1'b1 || rsp.data_rdata !== model[3]) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got early=%0d rvalid=%b gnt=%b data=%h expected 0/1/1/%h",
               bad_gnt, rsp.data_rvalid, rsp.data_gnt, rsp.data_rdata, model[3]);
    end
    @(posedge clk); #1;
    req.data_req = 1'b0; req.tag_valid = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (rsp.data_rvalid && rv_cycle < 0) begin rv_cycle = k; data = rsp.data_rdata; end
      @(posedge clk); #1; req.tag_valid = 1'b0;
    end
    exp_reads += 2;
    n_checks++;
    if (rv_cycle !== LAT + 1 || data !== model[4] || num_reads !== 16'(exp_reads)) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got cycle=%0d data=%h reads=%0d expected %0d/%h/%0d",
               rv_cycle, data, num_reads, LAT + 1, model[4], exp_reads);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w, l, n, d, rv; logic [63:0] data;
    issue(12'h038, 44'h0, 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
    req = '0; req.data_req = 1'b1; req.address_index = 12'h038;
    @(posedge clk); #1;
    req.data_req = 1'b0; req.tag_valid = 1'b1;
    @(posedge clk); #1;
    req.tag_valid = 1'b0; req.data_req = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp.data_gnt !== 1'b0 || rsp.data_rvalid !== 1'b0 || rsp.data_rdata !== 64'h0 ||
        num_reads !== 16'h0 || num_kills !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_wait: got busy=%b gnt=%b rvalid=%b rdata=%h reads=%0d kills=%0d expected zeros",
               busy, rsp.data_gnt, rsp.data_rvalid, rsp.data_rdata, num_reads, num_kills);
    end
    req.data_req = 1'b0;
    @(posedge clk); #3 rst_ni = 1'b1;
    init_model();
    rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (rsp.data_rvalid) rv++;
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (rv !== 0) begin
      n_fail++; $display("[TB] FAIL reset_no_rvalid: got %0d rvalids expected 0", rv);
    end
    issue(12'h038, 44'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
    exp_reads++;
    n_checks++;
    if (data !== model[7] || num_reads !== 16'(exp_reads)) begin
      n_fail++;
      $display("[TB] FAIL reset_mem_reinit: got %h reads=%0d expected %h/%0d", data, num_reads, model[7], exp_reads);
    end
  endtask

  task automatic test_saturation();
    int w, l, n, d; logic [63:0] data;
    logic [15:0] exp_sat [3];
    exp_sat[0] = 16'hFFFE; exp_sat[1] = 16'hFFFF; exp_sat[2] = 16'hFFFF;
    force dut.num_reads_q = 16'hFFFD;
    #1 release dut.num_reads_q;
    for (int i = 0; i < 3; i++) begin
      issue(12'($urandom), 44'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0, w, l, n, d, data);
      n_checks++;
      if (num_reads !== exp_sat[i]) begin
        n_fail++; $display("[TB] FAIL sat_reads[%0d]: got %h expected %h", i, num_reads, exp_sat[i]);
      end
    end
    force dut.num_kills_q = 16'hFFFE;
    #1 release dut.num_kills_q;
    for (int i = 1; i < 3; i++) begin
      issue(12'($urandom), 44'h0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 1'b0, w, l, n, d, data);
      n_checks++;
      if (num_kills !== exp_sat[i]) begin
        n_fail++; $display("[TB] FAIL sat_kills[%0d]: got %h expected %h", i, num_kills, exp_sat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_kill();
    test_random();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dcache_port_responder.md
DCACHE_PORT_RESPONDER -- requirements
Module: dcache_port_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, number of 64-bit backing words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from tag phase to data_rvalid (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  input  dcache_req_i_t  initiator request (index phase, tag phase, kill, write data).
REQ-006 SHALL have port req_o  output  dcache_req_o_t  data_gnt, data_rvalid, data_rdata back to initiator.
REQ-007 SHALL have port stall_i  input  1  back-pressure; forces data_gnt low while high.
REQ-008 SHALL have port busy_o  input-independent output  1  high when a request is outstanding (state != IDLE).
REQ-009 SHALL have port num_reads_o  output  16  saturating count of completed reads (rvalid pulses).
REQ-010 SHALL have port num_kills_o  output  16  saturating count of dropped (killed or tag-less) requests.

Function
REQ-011 SHALL implement states IDLE, TAG, WAIT, RESP; one request outstanding at most.
REQ-012 SHALL assert data_gnt combinationally = req_i.data_req && !stall_i && (state==IDLE || state==RESP).
REQ-013 SHALL, on data_gnt, capture address_index, data_we, data_be, data_wdata and enter TAG next cycle.
REQ-014 SHALL treat the cycle after grant as the tag phase: word address = ({address_tag, captured index} >> 3) modulo MEM_WORDS.
REQ-015 SHALL in TAG, if kill_req high or tag_valid low: drop request, no rvalid, increment num_kills_o, go IDLE.
REQ-016 SHALL in TAG with valid tag and captured data_we=1: write bytes of wdata where be[b]=1 into the addressed word, no rvalid, go IDLE.
REQ-017 SHALL in TAG with valid tag and read: latch word address, load counter with LATENCY-1; go RESP if LATENCY==1, else WAIT.
REQ-018 SHALL in WAIT decrement counter each cycle; go RESP when counter reaches 1; kill_req high in WAIT drops request (count kill, go IDLE).
REQ-019 SHALL in RESP drive data_rvalid=1 for exactly one cycle with data_rdata = addressed word, read at RESP time (reflects any earlier write).
REQ-020 SHALL in RESP ignore kill_req; go TAG if a new grant issues that cycle, else IDLE (back-to-back throughput: one read per LATENCY+1 cycles).
REQ-021 SHALL drive data_rdata = 0 whenever data_rvalid is 0.
REQ-022 SHALL ignore data_size; reads always return the full 64-bit word.
REQ-023 SHALL increment num_reads_o on each rvalid cycle; both counters hold at 16'hFFFF.
REQ-024 SHALL ignore req_i.data_req in TAG and WAIT (no grant; initiator holds request until granted).

Reset
REQ-025 SHALL on rst_ni low, immediately and regardless of state: state=IDLE, counter=0, data_gnt=0, data_rvalid=0, data_rdata=0, busy_o=0, both statistics counters=0.
REQ-026 SHALL on reset initialise backing word i to {32'(i), 32'(~i)}.
REQ-027 SHALL abandon any outstanding request on reset mid-operation; no rvalid after reset release for that request.

Verification
REQ-028 Read: LATENCY=2, data_req with index=0x010, tag phase tag=0 -> gnt same cycle, rvalid 3 cycles after gnt, rdata=64'h00000002_FFFFFFFD, num_reads_o=1.
REQ-029 Write then read: write word 5 be=8'h0F wdata=64'h1111_2222_3333_4444 -> next read of word 5 returns 64'h00000005_33334444... low bytes 0x33334444 with upper 32'h00000005 preserved.
REQ-030 Kill: grant, then kill_req=1 in tag phase -> no rvalid, num_kills_o=1, busy_o low next cycle; repeat with kill in WAIT -> same result.
REQ-031 Stall/back-to-back: stall_i=1 for 4 cycles with data_req held -> gnt low throughout; release -> gnt; second req held during RESP -> granted in RESP cycle, rvalid every LATENCY+1 cycles.
REQ-032 Reset mid-WAIT: assert rst_ni=0 during WAIT -> outputs zero asynchronously, memory reinitialised, no rvalid after release.
REQ-033 Saturation: force 65537 reads -> num_reads_o holds 16'hFFFF.
